// File: rtl/spi_slave_regs.sv
// SPI mode-3 slave in front of a 16 x 8-bit register file.
// Reg 15 is a read-only counter of frames that carried at least one complete data byte.
module spi_slave_regs #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  input  logic         spi_clk_i,
  input  logic         spi_mosi_i,
  input  logic         spi_cs_i,
  output logic         spi_miso_o,
  output logic [127:0] regs_o,
  output logic         wr_strobe_o,
  output logic [3:0]   wr_addr_o
);

  localparam int unsigned NUM_REGS = 16;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned CNT_W    = 3;
  localparam int unsigned FLUSH_W  = 3;
  localparam logic [FLUSH_W-1:0] FLUSH_CYCLES = FLUSH_W'(SYNC_STAGES + 1);
  localparam logic [ADDR_W-1:0]  CNT_REG      = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    WDATA,
    RDATA
  } state_e;

  // Synchronizers and previous-value flops for edge detection
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic                   sclk_prev_q;
  logic                   cs_prev_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sclk_sync_q <= '1;
      mosi_sync_q <= '0;
      cs_sync_q   <= '1;
      sclk_prev_q <= 1'b1;
      cs_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_i};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
      cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
    end
  end

  logic sclk_s;
  logic mosi_s;
  logic cs_s;
  logic sclk_rise;
  logic sclk_fall;
  logic cs_rise;
  logic cs_fall;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q & ~cs_s;
  assign sclk_fall = ~sclk_s & sclk_prev_q & ~cs_s;
  assign cs_rise   = cs_s & ~cs_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;

  state_e              state_q,    state_d;
  logic [CNT_W-1:0]    bit_cnt_q,  bit_cnt_d;
  logic [DATA_W-2:0]   rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0]   tx_shift_q, tx_shift_d;
  logic [ADDR_W-1:0]   addr_q,     addr_d;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic                miso_q,     miso_d;
  logic                strobe_q,   strobe_d;
  logic [ADDR_W-1:0]   wr_addr_q,  wr_addr_d;
  logic                got_byte_q, got_byte_d;
  logic                armed_q,    armed_d;
  logic [FLUSH_W-1:0]  flush_q,    flush_d;

  logic [DATA_W-1:0]   rx_byte;
  logic [ADDR_W-1:0]   addr_next;
  logic                byte_done;

  assign rx_byte   = {rx_shift_q, mosi_s};
  assign addr_next = addr_q + 4'd1;
  assign byte_done = (bit_cnt_q == 3'd7);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      addr_q     <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      miso_q     <= 1'b0;
      strobe_q   <= 1'b0;
      wr_addr_q  <= '0;
      got_byte_q <= 1'b0;
      armed_q    <= 1'b0;
      flush_q    <= FLUSH_CYCLES;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      addr_q     <= addr_d;
      regs_q     <= regs_d;
      miso_q     <= miso_d;
      strobe_q   <= strobe_d;
      wr_addr_q  <= wr_addr_d;
      got_byte_q <= got_byte_d;
      armed_q    <= armed_d;
      flush_q    <= flush_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    addr_d     = addr_q;
    regs_d     = regs_q;
    miso_d     = miso_q;
    strobe_d   = 1'b0;
    wr_addr_d  = wr_addr_q;
    got_byte_d = got_byte_q;
    armed_d    = armed_q;
    flush_d    = flush_q;

    // After reset, accept a frame only once the flushed synchronizer shows CS high
    if (flush_q != '0) begin
      flush_d = flush_q - 3'd1;
    end else if (cs_s && cs_prev_q) begin
      armed_d = 1'b1;
    end

    if (state_q != IDLE && cs_rise) begin
      state_d    = IDLE;
      bit_cnt_d  = '0;
      miso_d     = 1'b0;
      got_byte_d = 1'b0;
      if (got_byte_q) begin
        regs_d[CNT_REG] = regs_q[CNT_REG] + 8'd1;
      end
    end else begin
      case (state_q)
        IDLE: begin
          miso_d = 1'b0;
          if (armed_q && cs_fall) begin
            state_d    = CMD;
            bit_cnt_d  = '0;
            got_byte_d = 1'b0;
          end
        end
        CMD: begin
          miso_d = 1'b0;
          if (sclk_rise) begin
            rx_shift_d = rx_byte[DATA_W-2:0];
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (byte_done) begin
              addr_d = rx_byte[ADDR_W-1:0];
              if (rx_byte[DATA_W-1]) begin
                state_d    = RDATA;
                tx_shift_d = regs_q[rx_byte[ADDR_W-1:0]];
              end else begin
                state_d = WDATA;
              end
            end
          end
        end
        WDATA: begin
          if (sclk_rise) begin
            rx_shift_d = rx_byte[DATA_W-2:0];
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (byte_done) begin
              got_byte_d = 1'b1;
              addr_d     = addr_next;
              if (addr_q != CNT_REG) begin
                regs_d[addr_q] = rx_byte;
                strobe_d       = 1'b1;
                wr_addr_d      = addr_q;
              end
            end
          end
        end
        RDATA: begin
          if (sclk_fall) begin
            miso_d     = tx_shift_q[DATA_W-1];
            tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
          end else if (sclk_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (byte_done) begin
              got_byte_d = 1'b1;
              addr_d     = addr_next;
              tx_shift_d = regs_q[addr_next];
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_comb begin
    regs_o = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      regs_o[i*DATA_W +: DATA_W] = regs_q[i];
    end
  end

  assign spi_miso_o  = miso_q;
  assign wr_strobe_o = strobe_q;
  assign wr_addr_o   = wr_addr_q;

endmodule

// File: tb/tb_spi_slave_regs.sv
// Bench for spi_slave_regs: SPI master driven from sys_clk, checked against a frame-level register model.
module tb_spi_slave_regs;

  localparam int unsigned HALF = 5;

  logic         sys_clk;
  logic         sys_rst;
  logic         spi_clk;
  logic         spi_mosi;
  logic         spi_cs;
  logic         spi_miso_o;
  logic [127:0] regs_o;
  logic         wr_strobe_o;
  logic [3:0]   wr_addr_o;

  spi_slave_regs #(.SYNC_STAGES(2)) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .spi_clk_i   (spi_clk),
    .spi_mosi_i  (spi_mosi),
    .spi_cs_i    (spi_cs),
    .spi_miso_o  (spi_miso_o),
    .regs_o      (regs_o),
    .wr_strobe_o (wr_strobe_o),
    .wr_addr_o   (wr_addr_o)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_pass   = 0;
  int strobe_cnt = 0;
  bit idle_chk = 0;

  logic [7:0] model_regs [16];
  logic [7:0] tx_bytes [8];
  logic [7:0] rx_bytes [8];
  logic [7:0] exp_rx   [8];
  logic [3:0] exp_sa [$];
  logic [7:0] exp_sd [$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  function automatic logic [127:0] model_flat();
    logic [127:0] f;
    for (int i = 0; i < 16; i++) f[i*8 +: 8] = model_regs[i];
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) model_regs[i] = 8'h00;
    exp_sa.delete();
    exp_sd.delete();
  endtask

  // Frame effect: byte 0 is the command, the rest are data; partial trailing bits do nothing
  task automatic model_frame(input int nfull);
    logic [7:0] c;
    logic [3:0] a;
    if (nfull < 1) return;
    c = tx_bytes[0];
    a = c[3:0];
    exp_rx[0] = 8'h00;
    for (int i = 1; i < nfull; i++) begin
      if (c[7]) exp_rx[i] = model_regs[a];
      else if (a != 4'd15) begin
        model_regs[a] = tx_bytes[i];
        exp_sa.push_back(a);
        exp_sd.push_back(tx_bytes[i]);
      end
      a = a + 4'd1;
    end
    if (nfull > 1) model_regs[15] = model_regs[15] + 8'd1;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic spi_xfer(input int nfull, input int npart, input bit end_frame);
    logic [7:0] b;
    logic [7:0] r;
    int nbytes;
    int nb;
    nbytes = nfull + ((npart > 0) ? 1 : 0);
    spi_cs = 1'b0;
    wait_cyc(HALF);
    for (int i = 0; i < nbytes; i++) begin
      b  = tx_bytes[i];
      r  = 8'h00;
      nb = (i < nfull) ? 8 : npart;
      for (int k = 0; k < nb; k++) begin
        spi_clk  = 1'b0;
        spi_mosi = b[7];
        b = {b[6:0], 1'b0};
        wait_cyc(HALF);
        r = {r[6:0], spi_miso_o};
        spi_clk = 1'b1;
        wait_cyc(HALF);
      end
      if (i < nfull) rx_bytes[i] = r;
    end
    if (end_frame) begin
      spi_cs = 1'b1;
      wait_cyc(2 * HALF + 4);
      idle_chk = 1'b1;
    end
  endtask

  task automatic frame(input int nfull, input int npart);
    idle_chk = 1'b0;
    model_frame(nfull);
    spi_xfer(nfull, npart, 1'b1);
    if (nfull > 0 && tx_bytes[0][7]) begin
      for (int i = 0; i < nfull; i++) check($sformatf("miso_byte%0d", i), 128'(rx_bytes[i]), 128'(exp_rx[i]));
    end
  endtask

  task automatic do_reset();
    idle_chk = 1'b0;
    sys_rst = 1'b1;
    wait_cyc(3);
    check("reset_regs", regs_o, 128'h0);
    check("reset_miso", 128'(spi_miso_o), 128'h0);
    check("reset_strobe", 128'(wr_strobe_o), 128'h0);
    check("reset_wr_addr", 128'(wr_addr_o), 128'h0);
    model_reset();
    sys_rst = 1'b0;
  endtask

  // Per-cycle compare: every strobe against the expected write queue, idle state against the model
  logic [3:0] cmp_a;
  logic [7:0] cmp_d;
  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      if (wr_strobe_o) begin
        strobe_cnt++;
        if (exp_sa.size() == 0) begin
          check("unexpected_strobe", 128'(wr_addr_o), 128'hFFFF);
        end else begin
          cmp_a = exp_sa.pop_front();
          cmp_d = exp_sd.pop_front();
          check("strobe_addr", 128'(wr_addr_o), 128'(cmp_a));
          check("strobe_data", 128'(regs_o[cmp_a*8 +: 8]), 128'(cmp_d));
        end
      end
      if (idle_chk) begin
        check("regs_idle", regs_o, model_flat());
        check("miso_idle", 128'(spi_miso_o), 128'h0);
      end
    end
  end

  initial begin
    #(95000 * 10);
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s0;
    int nf;
    int np;
    sys_rst  = 1'b1;
    spi_clk  = 1'b1;
    spi_mosi = 1'b0;
    spi_cs   = 1'b1;
    do_reset();
    wait_cyc(2 * HALF + 4);
    idle_chk = 1'b1;

    // Single write
    s0 = strobe_cnt;
    tx_bytes[0] = 8'h03; tx_bytes[1] = 8'hA5;
    frame(2, 0);
    check("c1_reg3", 128'(regs_o[31:24]), 128'hA5);
    check("c1_reg15", 128'(regs_o[127:120]), 128'h01);
    check("c1_strobes", 128'(strobe_cnt - s0), 128'd1);
    check("c1_wr_addr", 128'(wr_addr_o), 128'd3);

    // Burst write wrapping through the read-only counter
    s0 = strobe_cnt;
    tx_bytes[0] = 8'h0E; tx_bytes[1] = 8'h11; tx_bytes[2] = 8'h22; tx_bytes[3] = 8'h33;
    frame(4, 0);
    check("c2_reg14", 128'(regs_o[119:112]), 128'h11);
    check("c2_reg0", 128'(regs_o[7:0]), 128'h33);
    check("c2_reg15", 128'(regs_o[127:120]), 128'h02);
    check("c2_strobes", 128'(strobe_cnt - s0), 128'd2);

    // Burst read of reg3/reg4
    tx_bytes[0] = 8'h04; tx_bytes[1] = 8'h5A;
    frame(2, 0);
    tx_bytes[0] = 8'h83; tx_bytes[1] = 8'h00; tx_bytes[2] = 8'h00;
    frame(3, 0);
    check("c3_miso0", 128'(rx_bytes[0]), 128'h00);
    check("c3_miso1", 128'(rx_bytes[1]), 128'hA5);
    check("c3_miso2", 128'(rx_bytes[2]), 128'h5A);

    // Partial data byte is discarded
    tx_bytes[0] = 8'h02; tx_bytes[1] = 8'h3C;
    frame(2, 0);
    s0 = strobe_cnt;
    tx_bytes[0] = 8'h02; tx_bytes[1] = 8'hFF;
    frame(1, 5);
    check("c4_reg2", 128'(regs_o[23:16]), 128'h3C);
    check("c4_strobes", 128'(strobe_cnt - s0), 128'd0);
    check("c4_reg15", 128'(regs_o[127:120]), 128'h05);

    // Reset after the 4th data bit, then the rest of that CS-low frame must be ignored
    idle_chk = 1'b0;
    tx_bytes[0] = 8'h01; tx_bytes[1] = 8'hF0;
    spi_xfer(1, 4, 1'b0);
    do_reset();
    wait_cyc(2 * HALF);
    tx_bytes[0] = 8'h05; tx_bytes[1] = 8'hFF;
    spi_xfer(2, 0, 1'b1);
    check("c5_regs_zero", regs_o, 128'h0);
    tx_bytes[0] = 8'h01; tx_bytes[1] = 8'h7E;
    frame(2, 0);
    check("c5_reg1", 128'(regs_o[15:8]), 128'h7E);

    // 256 counted frames wrap the counter back to zero
    do_reset();
    wait_cyc(2 * HALF + 4);
    idle_chk = 1'b1;
    for (int i = 0; i < 256; i++) begin
      tx_bytes[0] = 8'($urandom_range(0, 15));
      tx_bytes[1] = 8'($urandom);
      frame(2, 0);
    end
    check("c6_reg15_wrap", 128'(regs_o[127:120]), 128'h00);

    // Random reads, writes and truncated frames
    for (int i = 0; i < 25; i++) begin
      nf = $urandom_range(0, 5);
      np = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      for (int k = 0; k < 8; k++) tx_bytes[k] = 8'($urandom);
      frame(nf, np);
    end

    wait_cyc(4);
    check("strobe_queue_empty", 128'(exp_sa.size()), 128'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
